gps_ca_code_nco: RTL

- Parametrised GPS L1 C/A code generator driven by a chip-rate NCO.
- Produces early, prompt and late code replicas, a chip counter and an epoch pulse for one tracking channel.
- Supports any PRN 1..32 via G2 tap-pair select, and loading an arbitrary start code phase by LFSR slewing.
- Sits between the channel controller (fcw, sv_num, phase) and the correlators.

---
 rtl/gps_ca_code_nco.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gps_ca_code_nco.sv
// GPS L1 C/A code generator for one tracking channel: G1/G2 Gold-code LFSRs
// stepped by a chip-rate NCO, with early/prompt/late replicas and epoch marking.
module gps_ca_code_nco #(
    parameter int NCO_W = 32,
    parameter int SV_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [SV_W-1:0]  sv_num,
    input  logic [9:0]       phase_init,
    input  logic [NCO_W-1:0] fcw,
    output logic             code_early,
    output logic             code_prompt,
    output logic             code_late,
    output logic [9:0]       chip_cnt,
    output logic             chip_stb,
    output logic             epoch,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLEW = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [9:0]       g1;
    logic [9:0]       g2;
    logic [9:0]       tap_mask;
    logic [9:0]       phase_q;
    logic [10:0]      slew_left;
    logic [NCO_W-1:0] acc;

    // Stage n of an LFSR lives in bit n-1; the G2 tap pair is held as a
    // two-hot mask so the generator bit is a parity over the masked stages.
    function automatic logic [9:0] pair(input int a, input int b);
        return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    function automatic logic [9:0] tap_mask_of(input logic [SV_W-1:0] prn);
        case (int'(prn))
            1:  return pair(2, 6);
            2:  return pair(3, 7);
            3:  return pair(4, 8);
            4:  return pair(5, 9);
            5:  return pair(1, 9);
            6:  return pair(2, 10);
            7:  return pair(1, 8);
            8:  return pair(2, 9);
            9:  return pair(3, 10);
            10: return pair(2, 3);
            11: return pair(3, 4);
            12: return pair(5, 6);
            13: return pair(6, 7);
            14: return pair(7, 8);
            15: return pair(8, 9);
            16: return pair(9, 10);
            17: return pair(1, 4);
            18: return pair(2, 5);
            19: return pair(3, 6);
            20: return pair(4, 7);
            21: return pair(5, 8);
            22: return pair(6, 9);
            23: return pair(1, 3);
            24: return pair(4, 6);
            25: return pair(5, 7);
            26: return pair(6, 8);
            27: return pair(7, 9);
            28: return pair(8, 10);
            29: return pair(1, 6);
            30: return pair(2, 7);
            31: return pair(3, 8);
            32: return pair(4, 9);
            default: return 10'd0;
        endcase
    endfunction

    logic [NCO_W:0] sum;
    logic           carry;
    logic           step;
    logic           gen_bit;
    logic           g1_fb;
    logic           g2_fb;
    logic [9:0]     next_cnt;
    logic [9:0]     load_mask;
    logic           load_phase_ok;
    logic [9:0]     load_phase;
    logic [10:0]    load_steps;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, fcw};
        carry    = (state == RUN) && enable && sum[NCO_W];
        step     = (state == SLEW) || carry;
        g1_fb    = g1[2] ^ g1[9];
        g2_fb    = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
        // An empty mask marks an invalid PRN and forces the code to zero.
        gen_bit  = (|tap_mask) & (g1[9] ^ (^(g2 & tap_mask)));
        next_cnt = (chip_cnt == 10'd1022) ? 10'd0 : chip_cnt + 10'd1;

        load_mask     = tap_mask_of(sv_num);
        load_phase_ok = (phase_init <= 10'd1022);
        load_phase    = load_phase_ok ? phase_init : 10'd0;
        // Two extra steps fill early and prompt; phase 0 takes a full period
        // more so that late already holds chip 1022.
        load_steps    = (load_phase == 10'd0) ? 11'd1025 : {1'b0, load_phase} + 11'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            g1          <= '1;
            g2          <= '1;
            tap_mask    <= '0;
            phase_q     <= '0;
            slew_left   <= '0;
            acc         <= '0;
            code_early  <= 1'b0;
            code_prompt <= 1'b0;
            code_late   <= 1'b0;
            chip_cnt    <= '0;
            chip_stb    <= 1'b0;
            epoch       <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (load) begin
            state       <= SLEW;
            g1          <= '1;
            g2          <= '1;
            tap_mask    <= load_mask;
            phase_q     <= load_phase;
            slew_left   <= load_steps;
            acc         <= '0;
            code_early  <= 1'b0;
            code_prompt <= 1'b0;
            code_late   <= 1'b0;
            chip_cnt    <= '0;
            chip_stb    <= 1'b0;
            epoch       <= 1'b0;
            busy        <= 1'b1;
            cfg_err     <= (load_mask == 10'd0) || !load_phase_ok;
        end else begin
            chip_stb <= 1'b0;
            epoch    <= 1'b0;

            if ((state == RUN) && enable) begin
                acc <= sum[NCO_W-1:0];
            end

            if (step) begin
                g1          <= {g1[8:0], g1_fb};
                g2          <= {g2[8:0], g2_fb};
                code_late   <= code_prompt;
                code_prompt <= code_early;
                code_early  <= gen_bit;
            end

            if (state == SLEW) begin
                slew_left <= slew_left - 11'd1;
                if (slew_left == 11'd1) begin
                    state    <= RUN;
                    busy     <= 1'b0;
                    chip_cnt <= phase_q;
                end
            end

            if (carry) begin
                chip_cnt <= next_cnt;
                chip_stb <= 1'b1;
                epoch    <= (next_cnt == 10'd0);
            end
        end
    end

endmodule
